// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multicycle control sequencer for the MSP430 CPU core
// Drives register-file strobes and the memory read/write handshake per instruction phase.
module cpu_sequencer #(
   parameter logic [15:0] RESET_VECTOR = 16'hFFFE,
   parameter int          MEM_TIMEOUT  = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mem_rdy,
   input  logic [1:0] fmt,
   input  logic [1:0] As,
   input  logic       Ad,
   input  logic [3:0] srcA,
   input  logic [3:0] dstA,
   input  logic       no_wb,
   input  logic       sr_upd,
   input  logic       jmp_taken,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic [1:0] addr_sel,
   output logic       ir_load,
   output logic       src_ext_ld,
   output logic       dst_ext_ld,
   output logic       op_ld,
   output logic       incPC,
   output logic       incSrc,
   output logic       branch,
   output logic       SRW,
   output logic       RW,
   output logic       busy,
   output logic       bus_err,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      RST_VEC = 4'd0,
      FETCH   = 4'd1,
      DECODE  = 4'd2,
      SRC_EXT = 4'd3,
      SRC_MEM = 4'd4,
      DST_EXT = 4'd5,
      DST_MEM = 4'd6,
      EXEC    = 4'd7,
      WB_MEM  = 4'd8,
      JUMP    = 4'd9,
      HALT    = 4'd15
   } state_t;

   localparam logic [3:0] TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);

   // The vector word is fetched via addr_sel=3, so only its alignment matters here.
   if (RESET_VECTOR[0] != 1'b0 || MEM_TIMEOUT < 1 || MEM_TIMEOUT > 15) begin : g_param_check
      $error("cpu_sequencer: RESET_VECTOR must be word aligned and MEM_TIMEOUT in 1..15");
   end

   state_t     cur;
   state_t     nxt;
   state_t     dst_phase;
   logic [3:0] wait_cnt;
   logic       err_q;
   logic       src_const;
   logic       dst_needs_ext;
   logic       dst_is_mem;
   logic       mem_state;
   logic       timeout;

   always_comb begin
      src_const     = (srcA == 4'd3) || (srcA == 4'd2 && As[1]);
      dst_needs_ext = (fmt == 2'd0) && Ad;
      dst_is_mem    = dst_needs_ext || (fmt == 2'd1 && As != 2'd0);
      dst_phase     = dst_needs_ext ? DST_EXT : EXEC;
      mem_state     = cur inside {RST_VEC, FETCH, SRC_EXT, SRC_MEM, DST_EXT, DST_MEM, WB_MEM};
      // A ready memory on the last allowed cycle still completes the access.
      timeout       = mem_state && !mem_rdy && (wait_cnt == TIMEOUT_LAST);
   end

   always_comb begin
      nxt        = cur;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      addr_sel   = 2'd0;
      ir_load    = 1'b0;
      src_ext_ld = 1'b0;
      dst_ext_ld = 1'b0;
      op_ld      = 1'b0;
      incPC      = 1'b0;
      incSrc     = 1'b0;
      branch     = 1'b0;
      SRW        = 1'b0;
      RW         = 1'b0;
      busy       = 1'b0;
      if (!reset) begin
         busy = (cur != FETCH);
         case (cur)
            RST_VEC: begin
               mem_rd   = 1'b1;
               addr_sel = 2'd3;
               if (mem_rdy) begin
                  branch = 1'b1;
                  nxt    = FETCH;
               end
            end
            FETCH: begin
               mem_rd = 1'b1;
               if (mem_rdy) begin
                  ir_load = 1'b1;
                  incPC   = 1'b1;
                  nxt     = DECODE;
               end
            end
            DECODE: begin
               if (fmt == 2'd2)                    nxt = JUMP;
               else if (fmt == 2'd3)               nxt = HALT;
               else if (src_const || As == 2'd0)   nxt = dst_phase;
               else if (As == 2'd1)                nxt = SRC_EXT;
               else                                nxt = SRC_MEM;
            end
            SRC_EXT: begin
               mem_rd = 1'b1;
               if (mem_rdy) begin
                  src_ext_ld = 1'b1;
                  incPC      = 1'b1;
                  nxt        = SRC_MEM;
               end
            end
            SRC_MEM: begin
               mem_rd   = 1'b1;
               addr_sel = 2'd1;
               if (mem_rdy) begin
                  op_ld  = 1'b1;
                  // @PC+ is an immediate: the PC itself steps past the literal.
                  incSrc = (As == 2'd3) && (srcA != 4'd0);
                  incPC  = (As == 2'd3) && (srcA == 4'd0);
                  nxt    = dst_phase;
               end
            end
            DST_EXT: begin
               mem_rd = 1'b1;
               if (mem_rdy) begin
                  dst_ext_ld = 1'b1;
                  incPC      = 1'b1;
                  nxt        = DST_MEM;
               end
            end
            DST_MEM: begin
               mem_rd   = 1'b1;
               addr_sel = 2'd2;
               if (mem_rdy) begin
                  op_ld = 1'b1;
                  nxt   = EXEC;
               end
            end
            EXEC: begin
               SRW = sr_upd;
               if (no_wb) begin
                  nxt = FETCH;
               end else if (dst_is_mem) begin
                  nxt = WB_MEM;
               end else begin
                  if (dstA == 4'd0) branch = 1'b1;
                  else              RW     = 1'b1;
                  nxt = FETCH;
               end
            end
            WB_MEM: begin
               mem_wr   = 1'b1;
               addr_sel = 2'd2;
               if (mem_rdy) nxt = FETCH;
            end
            JUMP: begin
               branch = jmp_taken;
               nxt    = FETCH;
            end
            HALT:    nxt = HALT;
            default: nxt = HALT;
         endcase
         if (timeout) nxt = HALT;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur      <= RST_VEC;
         wait_cnt <= 4'd0;
         err_q    <= 1'b0;
      end else begin
         cur <= nxt;
         if (nxt != cur)                wait_cnt <= 4'd0;
         else if (mem_state && !mem_rdy) wait_cnt <= wait_cnt + 4'd1;
         if (timeout) err_q <= 1'b1;
      end
   end

   assign bus_err = err_q;
   assign state   = cur;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer
// Phase-plan reference model, randomized instructions and memory wait states.
module tb_cpu_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       mem_rdy = 1'b0;
   logic [1:0] fmt = 2'd0;
   logic [1:0] As = 2'd0;
   logic       Ad = 1'b0;
   logic [3:0] srcA = 4'd0;
   logic [3:0] dstA = 4'd0;
   logic       no_wb = 1'b0;
   logic       sr_upd = 1'b0;
   logic       jmp_taken = 1'b0;
   logic       mem_rd, mem_wr, ir_load, src_ext_ld, dst_ext_ld, op_ld;
   logic       incPC, incSrc, branch, SRW, RW, busy, bus_err;
   logic [1:0] addr_sel;
   logic [3:0] state;

   cpu_sequencer dut (
      .clk(clk), .reset(reset), .mem_rdy(mem_rdy), .fmt(fmt), .As(As), .Ad(Ad),
      .srcA(srcA), .dstA(dstA), .no_wb(no_wb), .sr_upd(sr_upd), .jmp_taken(jmp_taken),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_sel(addr_sel), .ir_load(ir_load),
      .src_ext_ld(src_ext_ld), .dst_ext_ld(dst_ext_ld), .op_ld(op_ld), .incPC(incPC),
      .incSrc(incSrc), .branch(branch), .SRW(SRW), .RW(RW), .busy(busy),
      .bus_err(bus_err), .state(state)
   );

   always #5 clk = ~clk;

   localparam int P_RST = 0, P_FETCH = 1, P_DEC = 2, P_SEXT = 3, P_SMEM = 4, P_DEXT = 5;
   localparam int P_DMEM = 6, P_EXEC = 7, P_WB = 8, P_JUMP = 9, P_HALT = 15;
   localparam int TIMEOUT = 15;

   int   n_tests = 0;
   int   n_fail = 0;
   int   ph = P_RST;
   int   wcnt = 0;
   logic berr = 1'b0;
   int   plan[$];
   int   cyc;
   int   c_incpc, c_incsrc, c_branch, c_rw, c_srw, c_memwr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [14:0] outs_now();
      return {mem_rd, mem_wr, addr_sel, ir_load, src_ext_ld, dst_ext_ld, op_ld,
              incPC, incSrc, branch, SRW, RW, busy, bus_err};
   endfunction

   function automatic logic [14:0] expect_outs(input int p, input logic r);
      logic rd, wr, il, sl, dl, ol, ip, is, br, sw, w, dmem;
      logic [1:0] a;
      {rd, wr, il, sl, dl, ol, ip, is, br, sw, w} = '0;
      a    = 2'd0;
      dmem = (fmt == 2'd0 && Ad) || (fmt == 2'd1 && As != 2'd0);
      case (p)
         P_RST:   begin rd = 1; a = 2'd3; br = r; end
         P_FETCH: begin rd = 1; il = r; ip = r; end
         P_SEXT:  begin rd = 1; sl = r; ip = r; end
         P_SMEM:  begin rd = 1; a = 2'd1; ol = r;
                        is = r && As == 2'd3 && srcA != 4'd0;
                        ip = r && As == 2'd3 && srcA == 4'd0; end
         P_DEXT:  begin rd = 1; dl = r; ip = r; end
         P_DMEM:  begin rd = 1; a = 2'd2; ol = r; end
         P_EXEC:  begin sw = sr_upd;
                        if (!no_wb && !dmem) begin br = (dstA == 4'd0); w = (dstA != 4'd0); end end
         P_WB:    begin wr = 1; a = 2'd2; end
         P_JUMP:  br = jmp_taken;
         default: ;
      endcase
      return {rd, wr, a, il, sl, dl, ol, ip, is, br, sw, w, 1'(p != P_FETCH), berr};
   endfunction

   // Whole-instruction phase list after the fetch, derived from the decoded fields.
   function automatic void build_plan();
      logic cnst;
      plan = {P_DEC};
      if (fmt == 2'd2) plan.push_back(P_JUMP);
      else if (fmt == 2'd3) plan.push_back(P_HALT);
      else begin
         cnst = (srcA == 4'd3) || (srcA == 4'd2 && As >= 2'd2);
         if (!cnst && As == 2'd1) plan.push_back(P_SEXT);
         if (!cnst && As != 2'd0) plan.push_back(P_SMEM);
         if (fmt == 2'd0 && Ad) begin plan.push_back(P_DEXT); plan.push_back(P_DMEM); end
         plan.push_back(P_EXEC);
         if (!no_wb && ((fmt == 2'd0 && Ad) || (fmt == 2'd1 && As != 2'd0))) plan.push_back(P_WB);
      end
   endfunction

   function automatic void advance();
      wcnt = 0;
      if (ph == P_RST) ph = P_FETCH;
      else begin
         if (ph == P_FETCH) build_plan();
         if (plan.size() == 0) ph = P_FETCH;
         else ph = plan.pop_front();
      end
   endfunction

   function automatic logic rnd(input int pct);
      return int'($urandom_range(99)) < pct;
   endfunction

   task automatic step(input logic r);
      logic is_mem;
      mem_rdy = r;
      #1;
      chk($sformatf("state(ph%0d)", ph), 32'(state), 32'(ph));
      chk($sformatf("outs(ph%0d,rdy%0d)", ph, r), 32'(outs_now()), 32'(expect_outs(ph, r)));
      chk("incPC_branch_excl", 32'(incPC & branch), 32'd0);
      c_incpc += int'(incPC); c_incsrc += int'(incSrc); c_branch += int'(branch);
      c_rw += int'(RW); c_srw += int'(SRW); c_memwr += int'(mem_wr);
      is_mem = ph inside {P_RST, P_FETCH, P_SEXT, P_SMEM, P_DEXT, P_DMEM, P_WB};
      if (is_mem) begin
         if (r) advance();
         else begin
            wcnt++;
            if (wcnt == TIMEOUT) begin ph = P_HALT; berr = 1'b1; wcnt = 0; end
         end
      end else if (ph != P_HALT) advance();
      @(negedge clk);
   endtask

   task automatic clr();
      c_incpc = 0; c_incsrc = 0; c_branch = 0; c_rw = 0; c_srw = 0; c_memwr = 0;
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      chk("rst_async_state", 32'(state), 32'd0);
      chk("rst_async_outs", 32'(outs_now()), 32'd0);
      @(posedge clk);
      #1;
      chk("rst_held_state", 32'(state), 32'd0);
      chk("rst_held_outs", 32'(outs_now()), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      ph = P_RST; wcnt = 0; berr = 1'b0; plan = {};
   endtask

   task automatic set_fields(input logic [1:0] f, input logic [1:0] as, input logic ad,
                             input logic [3:0] sa, input logic [3:0] da,
                             input logic nw, input logic su, input logic jt);
      fmt = f; As = as; Ad = ad; srcA = sa; dstA = da; no_wb = nw; sr_upd = su; jmp_taken = jt;
   endtask

   task automatic run_instr(input int pct, output int cycles);
      clr();
      cycles = 0;
      while (ph == P_FETCH && cycles < 200) begin step(rnd(pct)); cycles++; end
      while (ph != P_FETCH && ph != P_HALT && cycles < 200) begin step(rnd(pct)); cycles++; end
      if (cycles >= 200) begin
         n_tests++; n_fail++;
         $display("FAIL instr_bound: got %0d cycles expected under 200", cycles);
      end
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: got no finish expected finish before 900000");
      $fatal(1);
   end

   initial begin
      int r, f, bound;
      do_reset();
      clr();
      step(1'b1);
      chk("rstvec_branch", 32'(c_branch), 32'd1);

      set_fields(2'd0, 2'd0, 1'b0, 4'd5, 4'd6, 1'b0, 1'b0, 1'b0);   // MOV R5,R6
      run_instr(100, cyc);
      chk("mov_reg_cycles", 32'(cyc), 32'd3);
      chk("mov_reg_rw", 32'(c_rw), 32'd1);

      set_fields(2'd0, 2'd3, 1'b1, 4'd4, 4'd7, 1'b0, 1'b1, 1'b0);   // ADD @R4+,2(R7)
      run_instr(100, cyc);
      chk("add_cycles", 32'(cyc), 32'd7);
      chk("add_incsrc", 32'(c_incsrc), 32'd1);
      chk("add_memwr", 32'(c_memwr), 32'd1);
      chk("add_srw", 32'(c_srw), 32'd1);
      chk("add_rw", 32'(c_rw), 32'd0);

      set_fields(2'd0, 2'd3, 1'b0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0);   // MOV #0x1234,R9
      run_instr(100, cyc);
      chk("imm_cycles", 32'(cyc), 32'd4);
      chk("imm_incpc", 32'(c_incpc), 32'd2);
      chk("imm_incsrc", 32'(c_incsrc), 32'd0);

      set_fields(2'd0, 2'd1, 1'b0, 4'd3, 4'd5, 1'b1, 1'b1, 1'b0);   // CMP #1,R5
      run_instr(100, cyc);
      chk("cmp_cycles", 32'(cyc), 32'd3);
      chk("cmp_rw", 32'(c_rw), 32'd0);
      chk("cmp_srw", 32'(c_srw), 32'd1);

      set_fields(2'd0, 2'd0, 1'b0, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0);   // MOV R5,PC
      run_instr(100, cyc);
      chk("movpc_branch", 32'(c_branch), 32'd1);
      chk("movpc_rw", 32'(c_rw), 32'd0);

      set_fields(2'd2, 2'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);   // JNE taken
      run_instr(100, cyc);
      chk("jmp_taken_branch", 32'(c_branch), 32'd1);
      set_fields(2'd2, 2'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);   // JNE not taken
      run_instr(100, cyc);
      chk("jmp_not_taken_branch", 32'(c_branch), 32'd0);
      chk("jmp_cycles", 32'(cyc), 32'd3);

      // Ready arriving on the last allowed wait cycle beats the timeout.
      set_fields(2'd0, 2'd0, 1'b0, 4'd5, 4'd6, 1'b0, 1'b0, 1'b0);
      repeat (TIMEOUT - 1) step(1'b0);
      step(1'b1);
      chk("late_rdy_state", 32'(state), 32'd2);
      chk("late_rdy_buserr", 32'(bus_err), 32'd0);
      while (ph != P_FETCH) step(1'b1);

      set_fields(2'd3, 2'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);   // illegal
      run_instr(100, cyc);
      repeat (3) step(1'b1);
      chk("illegal_state", 32'(state), 32'd15);
      chk("illegal_busy", 32'(busy), 32'd1);
      do_reset();
      step(1'b1);

      set_fields(2'd0, 2'd0, 1'b0, 4'd5, 4'd6, 1'b0, 1'b0, 1'b0);
      run_instr(0, cyc);
      chk("timeout_cycles", 32'(cyc), 32'd15);
      step(1'b1);
      chk("timeout_state", 32'(state), 32'd15);
      chk("timeout_buserr", 32'(bus_err), 32'd1);
      do_reset();
      chk("buserr_cleared", 32'(bus_err), 32'd0);
      step(1'b1);

      set_fields(2'd0, 2'd3, 1'b1, 4'd4, 4'd7, 1'b0, 1'b1, 1'b0);   // abort in DST_MEM
      clr();
      bound = 0;
      while (ph != P_DMEM && bound < 20) begin step(1'b1); bound++; end
      step(1'b0);
      chk("abort_in_dstmem", 32'(state), 32'd6);
      do_reset();
      chk("abort_rw", 32'(c_rw), 32'd0);
      chk("abort_srw", 32'(c_srw), 32'd0);
      chk("abort_memwr", 32'(c_memwr), 32'd0);

      for (int i = 0; i < 200; i++) begin
         if (ph == P_HALT) begin step(rnd(50)); do_reset(); end
         while (ph == P_RST) step(rnd(75));
         if (ph != P_FETCH) continue;
         r = int'($urandom_range(15));
         f = (r == 0) ? 3 : r % 3;
         set_fields(2'(f), 2'($urandom_range(3)), 1'($urandom_range(1)),
                    $urandom_range(1) != 0 ? 4'($urandom_range(3)) : 4'($urandom_range(15)),
                    $urandom_range(3) == 0 ? 4'd0 : 4'($urandom_range(15)),
                    1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
         if ($urandom_range(24) == 0) begin
            repeat ($urandom_range(6, 1)) step(rnd(75));
            do_reset();
         end else begin
            run_instr(75, cyc);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
